// File: rtl/anabellek_hakem.sv
// anabellek_hakem: arbiter/sequencer for the single main-memory (iomem) port.
// Shares the port between the instruction-cache controller (getir_*) and the
// data-cache controller (bellek_*). Data has priority; a starvation counter
// forces a pending fetch through after ACLIK_SINIRI consecutive data grants.
// Cached accesses run a 4-word line burst; data accesses to the IO region
// (adres[31:28] == IO_BOLGE) run a single word. A beat that waits
// ZAMAN_ASIMI cycles for ready aborts the transfer with hata_o.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   getir_istek_i/adres_i         fetch request (level) and line address
//   getir_hazir_o                 one-cycle fetch-done pulse
//   bellek_istek_i/yaz_i/adres_i  data request, write flag, address
//   bellek_veri_i                 128-bit write line (word i at [32i+31:32i])
//   bellek_hazir_o                one-cycle data-done pulse
//   okunan_veri_obegi_o           128-bit read line
//   hata_o                        timeout flag, pulses with the owner's hazir
//   mesgul_o                      high whenever not idle
//   iomem_*                       valid/ready memory bus
module anabellek_hakem #(
  parameter int          ACLIK_SINIRI = 4,
  parameter int          ZAMAN_ASIMI  = 255,
  parameter logic [3:0]  IO_BOLGE     = 4'h3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         getir_istek_i,
  input  logic [31:0]  getir_adres_i,
  output logic         getir_hazir_o,
  input  logic         bellek_istek_i,
  input  logic         bellek_yaz_i,
  input  logic [31:0]  bellek_adres_i,
  input  logic [127:0] bellek_veri_i,
  output logic         bellek_hazir_o,
  output logic [127:0] okunan_veri_obegi_o,
  output logic         hata_o,
  output logic         mesgul_o,
  output logic         iomem_valid_o,
  output logic [31:0]  iomem_addr_o,
  output logic [31:0]  iomem_wdata_o,
  output logic [3:0]   iomem_wstrb_o,
  input  logic         iomem_ready_i,
  input  logic [31:0]  iomem_rdata_i
);

  typedef enum logic [1:0] {BOSTA, ISTEK, BITTI} durum_t;

  durum_t         r_durum, w_durum_next;
  logic           r_sahip_veri, w_sahip_veri_next;  // 1 = data owns the bus
  logic           r_yaz, w_yaz_next;
  logic           r_valid, w_valid_next;
  logic           r_hata, w_hata_next;
  logic [1:0]     r_beat, w_beat_next;
  logic [1:0]     r_son_beat, w_son_beat_next;
  logic [31:0]    r_adres, w_adres_next;
  logic [7:0]     r_bekle, w_bekle_next;
  logic [3:0]     r_aclik, w_aclik_next;
  logic [127:0]   r_satir, w_satir_next;

  logic           w_veri_sec;
  logic           w_io;
  logic [31:0]    w_secili_adres;
  logic [31:0]    w_kelime [4];

  // Write-line word slicing, indexed by the current beat.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_kelime
      assign w_kelime[gi] = bellek_veri_i[32*gi +: 32];
    end
  endgenerate

  // Data wins unless fetch is pending and has already waited the limit.
  assign w_veri_sec     = bellek_istek_i &&
                          !(getir_istek_i && (r_aclik == 4'(ACLIK_SINIRI)));
  assign w_io           = w_veri_sec && (bellek_adres_i[31:28] == IO_BOLGE);
  assign w_secili_adres = w_veri_sec ? bellek_adres_i : getir_adres_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_durum      <= BOSTA;
      r_sahip_veri <= 1'b0;
      r_yaz        <= 1'b0;
      r_valid      <= 1'b0;
      r_hata       <= 1'b0;
      r_beat       <= 2'd0;
      r_son_beat   <= 2'd0;
      r_adres      <= 32'd0;
      r_bekle      <= 8'd0;
      r_aclik      <= 4'd0;
      r_satir      <= 128'd0;
    end else begin
      r_durum      <= w_durum_next;
      r_sahip_veri <= w_sahip_veri_next;
      r_yaz        <= w_yaz_next;
      r_valid      <= w_valid_next;
      r_hata       <= w_hata_next;
      r_beat       <= w_beat_next;
      r_son_beat   <= w_son_beat_next;
      r_adres      <= w_adres_next;
      r_bekle      <= w_bekle_next;
      r_aclik      <= w_aclik_next;
      r_satir      <= w_satir_next;
    end
  end

  always_comb begin
    w_durum_next      = r_durum;
    w_sahip_veri_next = r_sahip_veri;
    w_yaz_next        = r_yaz;
    w_valid_next      = r_valid;
    w_hata_next       = r_hata;
    w_beat_next       = r_beat;
    w_son_beat_next   = r_son_beat;
    w_adres_next      = r_adres;
    w_bekle_next      = r_bekle;
    w_aclik_next      = r_aclik;
    w_satir_next      = r_satir;

    case (r_durum)
      BOSTA: begin
        if (bellek_istek_i || getir_istek_i) begin
          w_durum_next      = ISTEK;
          w_valid_next      = 1'b1;
          w_hata_next       = 1'b0;
          w_sahip_veri_next = w_veri_sec;
          w_yaz_next        = w_veri_sec && bellek_yaz_i;
          w_beat_next       = 2'd0;
          w_son_beat_next   = w_io ? 2'd0 : 2'd3;
          w_bekle_next      = 8'd0;
          // Bursts start on the line boundary, single beats on the word.
          w_adres_next      = w_secili_adres & (w_io ? 32'hFFFF_FFFC : 32'hFFFF_FFF0);
          if (!w_veri_sec)
            w_aclik_next = 4'd0;
          else if (getir_istek_i && (r_aclik != 4'hF))
            w_aclik_next = r_aclik + 4'd1;
        end
      end

      ISTEK: begin
        if (iomem_ready_i) begin
          w_bekle_next = 8'd0;
          if (!r_yaz)
            w_satir_next[{r_beat, 5'b0} +: 32] = iomem_rdata_i;
          if (r_beat == r_son_beat) begin
            w_valid_next = 1'b0;
            w_hata_next  = 1'b0;
            w_durum_next = BITTI;
          end else begin
            w_beat_next  = r_beat + 2'd1;
            w_adres_next = r_adres + 32'd4;
          end
        end else if ((r_bekle + 8'd1) == 8'(ZAMAN_ASIMI)) begin
          // Abort: partial read data already captured stays in the line.
          w_valid_next = 1'b0;
          w_hata_next  = 1'b1;
          w_durum_next = BITTI;
        end else begin
          w_bekle_next = r_bekle + 8'd1;
        end
      end

      BITTI: begin
        // No arbitration here so a requester dropping istek on hazir is not re-granted.
        w_durum_next = BOSTA;
      end

      default: w_durum_next = BOSTA;
    endcase
  end

  assign getir_hazir_o       = (r_durum == BITTI) && !r_sahip_veri;
  assign bellek_hazir_o      = (r_durum == BITTI) && r_sahip_veri;
  assign hata_o              = (r_durum == BITTI) && r_hata;
  assign mesgul_o            = (r_durum != BOSTA);
  assign okunan_veri_obegi_o = r_satir;
  assign iomem_valid_o       = r_valid;
  assign iomem_addr_o        = r_adres;
  assign iomem_wstrb_o       = (r_valid && r_yaz) ? 4'b1111 : 4'b0000;
  assign iomem_wdata_o       = (r_valid && r_yaz) ? w_kelime[r_beat] : 32'd0;

endmodule
